// File: rtl/trace_reader.sv
// trace_reader: arms the trigger, reads a captured frame, streams scaled (x, y) points.
// Latency: first point 3 cycles after the capture_done rising edge; one point per 3 cycles.
// Backpressure: pt_valid/point held until pt_ready; trigger re-armed only after the last point.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   capture_done        trigger capture-complete level (edge-detected here)
//   arm                 trigger may capture (ARMED and not held)
//   hold                freeze display: blocks arming and new readouts
//   rd_addr / rd_data   capture buffer read port, data one cycle after address
//   pt_valid/pt_ready   point handshake to the plotter; pt_x, pt_y, pt_last payload
//   busy                readout in progress
//   frame_count         completed readouts (wrapping)
module trace_reader #(
  parameter int SAMPLES = 256,
  parameter int DATA_W  = 12,
  parameter int X_BASE  = 16,
  parameter int X_STEP  = 3,
  parameter int Y_BASE  = 540,
  parameter int Y_SHIFT = 3,
  localparam int IDX_W  = $clog2(SAMPLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_done,
  output logic              arm,
  input  logic              hold,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [10:0]       pt_x,
  output logic [9:0]        pt_y,
  output logic              pt_last,
  output logic              busy,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam logic [10:0]      X_BASE_C = 11'(X_BASE);
  localparam logic [10:0]      X_STEP_C = 11'(X_STEP);
  localparam logic [12:0]      Y_BASE_C = 13'(Y_BASE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx;
  logic               done_q;
  logic               start;
  logic               hs;
  logic [10:0]        x_next;
  logic [DATA_W-1:0]  samp_shift;
  logic [12:0]        y_diff;
  logic [9:0]         y_next;

  // done_q resets high so a level already present at reset release is not an edge.
  assign start = capture_done & ~done_q & (state_q == ARMED) & ~hold;
  assign hs    = pt_valid & pt_ready;
  assign arm   = (state_q == ARMED) & ~hold;
  assign busy  = (state_q != ARMED);

  // Screen mapping: x wraps modulo 2^11; y is a 13-bit signed difference,
  // negative clamps to the top of the screen, anything past 10 bits saturates.
  assign x_next     = X_BASE_C + 11'(idx) * X_STEP_C;
  assign samp_shift = rd_data >> Y_SHIFT;
  assign y_diff     = Y_BASE_C - 13'(samp_shift);

  always_comb begin
    y_next = y_diff[9:0];
    if (y_diff[12]) begin
      y_next = '0;
    end else if (|y_diff[11:10]) begin
      y_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: if (start) state_d = ADDR;
      ADDR:  state_d = DATA;
      DATA:  state_d = EMIT;
      EMIT: begin
        if (hs) begin
          state_d = pt_last ? ARMED : ADDR;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 1'b1;
      idx         <= '0;
      rd_addr     <= '0;
      pt_valid    <= 1'b0;
      pt_x        <= '0;
      pt_y        <= '0;
      pt_last     <= 1'b0;
      frame_count <= '0;
    end else begin
      done_q <= capture_done;
      case (state_q)
        ARMED: begin
          if (start) begin
            idx     <= '0;
            rd_addr <= '0;
          end
        end
        DATA: begin
          // rd_data corresponds to rd_addr presented during ADDR.
          pt_x     <= x_next;
          pt_y     <= y_next;
          pt_last  <= (idx == IDX_LAST);
          pt_valid <= 1'b1;
        end
        EMIT: begin
          if (hs) begin
            pt_valid <= 1'b0;
            if (pt_last) begin
              frame_count <= frame_count + 16'd1;
            end else begin
              idx     <= idx + 1'b1;
              rd_addr <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_reader.sv
// tb_trace_reader: directed bench for trace_reader.
// Main instance reads mem[i]=i*16; a second instance with Y_BASE=100 checks y clamping.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_trace_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_done;
  logic        hold;
  logic        pt_ready;

  logic        arm, pt_valid, pt_last, busy;
  logic [7:0]  rd_addr;
  logic [11:0] rd_data;
  logic [10:0] pt_x;
  logic [9:0]  pt_y;
  logic [15:0] frame_count;

  logic        arm_c, pt_valid_c, pt_last_c, busy_c;
  logic [7:0]  rd_addr_c;
  logic [11:0] rd_data_c;
  logic [10:0] pt_x_c;
  logic [9:0]  pt_y_c;
  logic [15:0] frame_count_c;

  logic [11:0] mem   [256];
  logic [11:0] mem_c [256];
  logic [9:0]  clamp_exp [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data   <= mem[rd_addr];
    rd_data_c <= mem_c[rd_addr_c];
  end

  trace_reader dut (
    .clk(clk), .rst(rst), .capture_done(capture_done), .arm(arm), .hold(hold),
    .rd_addr(rd_addr), .rd_data(rd_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last), .busy(busy), .frame_count(frame_count)
  );

  trace_reader #(.Y_BASE(100), .Y_SHIFT(3)) dut_c (
    .clk(clk), .rst(rst), .capture_done(capture_done), .arm(arm_c), .hold(hold),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c), .pt_valid(pt_valid_c), .pt_ready(pt_ready),
    .pt_x(pt_x_c), .pt_y(pt_y_c), .pt_last(pt_last_c), .busy(busy_c),
    .frame_count(frame_count_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Consumes one frame. capture_done was just raised at a falling edge; it drops
  // after 5 cycles, and hold is set then if requested. bp_idx < 0 disables the stall.
  task automatic collect_frame(input int bp_idx, input logic set_hold, input int exp_frames);
    int n = 0;
    int cyc = 0;
    int last_cyc = 0;
    while (n < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        capture_done = 1'b0;
        if (set_hold) hold = 1'b1;
      end
      if (pt_valid) begin
        if (n == 0) check("first_latency", cyc, 3);
        else        check("spacing", cyc - last_cyc, 3);
        if (n == bp_idx) begin
          pt_ready = 1'b0;
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cyc++;
            check("bp_valid", pt_valid, 1);
            check("bp_x", pt_x, 16 + 3 * n);
            check("bp_y", pt_y, 540 - 2 * n);
            check("bp_addr", rd_addr, n);
          end
          pt_ready = 1'b1;
        end
        check("pt_x", pt_x, 16 + 3 * n);
        check("pt_y", pt_y, 540 - 2 * n);
        check("pt_last", pt_last, (n == 255) ? 1 : 0);
        check("arm_busy", {arm, busy}, 2'b01);
        check("frames_mid", frame_count, exp_frames - 1);
        if (n < 4) check("clamp_y", pt_y_c, clamp_exp[n]);
        last_cyc = cyc;
        n++;
      end
    end
    check("frame_points", n, 256);
    @(negedge clk);
    check("post_arm", arm, set_hold ? 0 : 1);
    check("post_busy", busy, 0);
    check("post_valid", pt_valid, 0);
    check("post_frames", frame_count, exp_frames);
  endtask

  initial begin
    int found;
    for (int i = 0; i < 256; i++) begin
      mem[i]   = 12'(i * 16);
      mem_c[i] = 12'd0;
    end
    mem_c[0] = 12'd4095;
    mem_c[1] = 12'd800;
    mem_c[2] = 12'd792;
    mem_c[3] = 12'd0;
    clamp_exp[0] = 10'd0;
    clamp_exp[1] = 10'd0;
    clamp_exp[2] = 10'd1;
    clamp_exp[3] = 10'd100;

    // Reset with capture_done already high.
    rst = 1'b1; capture_done = 1'b1; hold = 1'b0; pt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_arm", arm, 1);
    check("rst_valid", pt_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frames", frame_count, 0);
    check("rst_xy", {pt_x, pt_y, pt_last, rd_addr}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("level_at_reset_busy", busy, 0);
    check("level_at_reset_valid", pt_valid, 0);

    // Frame 1 with a 10-cycle stall on point 5.
    capture_done = 1'b0;
    repeat (2) @(negedge clk);
    capture_done = 1'b1;
    collect_frame(5, 1'b0, 1);

    // Hold blocks arming and a rising edge; releasing with the level high does nothing.
    hold = 1'b1;
    @(negedge clk);
    check("hold_arm", arm, 0);
    capture_done = 1'b1;
    repeat (6) @(negedge clk);
    check("hold_busy", busy, 0);
    check("hold_valid", pt_valid, 0);
    hold = 1'b0;
    @(negedge clk);
    check("unhold_arm", arm, 1);
    repeat (5) @(negedge clk);
    check("unhold_level_busy", busy, 0);
    capture_done = 1'b0;
    @(negedge clk);
    capture_done = 1'b1;
    collect_frame(-1, 1'b0, 2);

    // Reset while point 100 is waiting.
    capture_done = 1'b0;
    @(negedge clk);
    capture_done = 1'b1;
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (c == 5) capture_done = 1'b0;
      if (pt_valid && pt_x == 11'd316) begin
        found = 1;
        pt_ready = 1'b0;
        rst = 1'b1;
      end
    end
    check("reach_point100", found, 1);
    @(negedge clk);
    check("midrst_valid", pt_valid, 0);
    check("midrst_arm", arm, 1);
    check("midrst_busy", busy, 0);
    check("midrst_frames", frame_count, 0);
    rst = 1'b0;
    pt_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("after_rst_busy", busy, 0);

    // Full frame from i=0; hold raised mid-frame does not abort it.
    capture_done = 1'b1;
    collect_frame(-1, 1'b1, 1);
    repeat (3) @(negedge clk);
    check("held_idle_busy", busy, 0);
    hold = 1'b0;
    @(negedge clk);
    check("final_arm", arm, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
